// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: synchronizer, debounce filter, edge pulses
// and sticky per-channel event flags combined into a single registered irq.
module input_conditioner #(
    parameter int unsigned         CHANNELS        = 8,
    parameter int unsigned         SYNC_STAGES     = 2,
    parameter int unsigned         DEBOUNCE_CYCLES = 4,
    parameter logic [CHANNELS-1:0] INIT            = '0
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [CHANNELS-1:0]   async_in,
    input  logic [2*CHANNELS-1:0] irq_mode,
    input  logic [CHANNELS-1:0]   clear,
    output logic [CHANNELS-1:0]   stable_out,
    output logic [CHANNELS-1:0]   rise_pulse,
    output logic [CHANNELS-1:0]   fall_pulse,
    output logic [CHANNELS-1:0]   pending,
    output logic                  irq
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q;
    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_d;
    logic [CHANNELS-1:0]                  sync_c;
    logic [CHANNELS-1:0]                  accept_c;
    logic [CHANNELS-1:0]                  stable_d;
    logic [CHANNELS-1:0]                  rise_d;
    logic [CHANNELS-1:0]                  fall_d;
    logic [CHANNELS-1:0]                  set_c;
    logic [CHANNELS-1:0]                  pending_d;

    assign sync_c = sync_q[SYNC_STAGES-1];

    // Synchronizer chains; stage 0 samples the raw pins.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            sync_q <= {SYNC_STAGES{INIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    // Debounce: count consecutive disagreeing samples; accept on the last one.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_out;
        accept_c = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sync_c[i] == stable_out[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]    = '0;
                stable_d[i] = sync_c[i];
                accept_c[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge classification and sticky flag update; a set wins over a clear.
    always_comb begin
        rise_d = accept_c & sync_c;
        fall_d = accept_c & ~sync_c;
        set_c  = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            set_c[i] = (rise_d[i] & irq_mode[2*i]) | (fall_d[i] & irq_mode[2*i+1]);
        end
        pending_d = set_c | (pending & ~clear);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt_q      <= '0;
            stable_out <= INIT;
            rise_pulse <= '0;
            fall_pulse <= '0;
            pending    <= '0;
            irq        <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            stable_out <= stable_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
            pending    <= pending_d;
            irq        <= |pending;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: an abstract window model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_input_conditioner;

    localparam int S = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        nreset;
    logic [7:0]  async_in;
    logic [15:0] irq_mode;
    logic [7:0]  clear;
    logic [7:0]  stable_out;
    logic [7:0]  rise_pulse;
    logic [7:0]  fall_pulse;
    logic [7:0]  pending;
    logic        irq;

    int checks = 0;
    int errors = 0;

    input_conditioner #(
        .CHANNELS(8),
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D),
        .INIT(8'h01)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .async_in(async_in),
        .irq_mode(irq_mode),
        .clear(clear),
        .stable_out(stable_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .pending(pending),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Model: a channel's stable level flips when the last D synchronized
    // samples all disagree with it; the synchronized sample at edge m is the
    // pin value captured S edges earlier, or the reset level near a reset.
    logic [7:0] init_v = 8'h01;
    logic [7:0] a_hist [0:4095];
    int         ecount = 0;
    int         last_reset = -1;
    bit         model_ok = 1'b0;
    logic [7:0] m_stable, m_rise, m_fall, m_pend;
    logic       m_irq;

    function automatic logic sync_bit(input int m, input int ch);
        if (m - S > last_reset) return a_hist[m-S][ch];
        return init_v[ch];
    endfunction

    always @(posedge clk) begin
        logic [7:0] nrise;
        logic [7:0] nfall;
        logic [7:0] setv;
        bit         flip;
        ecount = ecount + 1;
        a_hist[ecount] = async_in;
        if (!nreset) begin
            m_stable   = init_v;
            m_rise     = '0;
            m_fall     = '0;
            m_pend     = '0;
            m_irq      = 1'b0;
            last_reset = ecount;
            model_ok   = 1'b1;
        end else if (model_ok) begin
            m_irq = |m_pend;
            nrise = '0;
            nfall = '0;
            setv  = '0;
            for (int ch = 0; ch < 8; ch++) begin
                flip = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (sync_bit(ecount - j, ch) == m_stable[ch]) flip = 1'b0;
                end
                if (flip) begin
                    nrise[ch]    = ~m_stable[ch];
                    nfall[ch]    = m_stable[ch];
                    m_stable[ch] = ~m_stable[ch];
                end
                setv[ch] = (nrise[ch] & irq_mode[2*ch]) | (nfall[ch] & irq_mode[2*ch+1]);
            end
            m_pend = setv | (m_pend & ~clear);
            m_rise = nrise;
            m_fall = nfall;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    // Advance one edge, then compare every output with the model.
    task automatic step();
        @(negedge clk);
        if (model_ok) begin
            chk("model_stable", 32'(stable_out), 32'(m_stable));
            chk("model_rise", 32'(rise_pulse), 32'(m_rise));
            chk("model_fall", 32'(fall_pulse), 32'(m_fall));
            chk("model_pending", 32'(pending), 32'(m_pend));
            chk("model_irq", 32'(irq), 32'(m_irq));
        end
    endtask

    typedef struct {
        logic [7:0] val;
        int         hold;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        nreset   = 1'b0;
        async_in = 8'h01;
        irq_mode = 16'h0000;
        clear    = 8'h00;

        // Reset held for three edges, then twenty quiet cycles.
        repeat (3) step();
        chk("rst_stable", 32'(stable_out), 32'h01);
        chk("rst_pending", 32'(pending), 32'h00);
        chk("rst_irq", 32'(irq), 32'h0);
        nreset = 1'b1;
        repeat (20) step();
        chk("quiet_stable", 32'(stable_out), 32'h01);
        chk("quiet_pulses", 32'({rise_pulse, fall_pulse}), 32'h0);
        chk("quiet_irq", 32'({pending, irq}), 32'h0);

        // Clean rise on channel 2.
        irq_mode = 16'h0010;
        async_in = 8'h05;
        repeat (5) step();
        chk("rise_early_stable", 32'(stable_out), 32'h01);
        step();
        chk("rise_stable", 32'(stable_out), 32'h05);
        chk("rise_pulse_hi", 32'(rise_pulse), 32'h04);
        chk("rise_pending", 32'(pending), 32'h04);
        chk("rise_irq_lag", 32'(irq), 32'h0);
        step();
        chk("rise_pulse_lo", 32'(rise_pulse), 32'h00);
        chk("rise_irq", 32'(irq), 32'h1);
        clear = 8'h04;
        step();
        clear = 8'h00;
        chk("clr_pending", 32'(pending), 32'h00);
        step();
        chk("clr_irq", 32'(irq), 32'h0);

        // Three-edge glitch on channel 3 must be rejected.
        irq_mode = 16'h0050;
        async_in = 8'h0D;
        repeat (3) step();
        async_in = 8'h05;
        repeat (8) step();
        chk("glitch_stable", 32'(stable_out), 32'h05);
        chk("glitch_pending", 32'(pending), 32'h00);

        // Channel 0 fall accepted on the same edge as its clear strobe.
        irq_mode = 16'h0053;
        async_in = 8'h04;
        repeat (5) step();
        clear = 8'h01;
        step();
        chk("coll_fall", 32'(fall_pulse), 32'h01);
        chk("coll_pending", 32'(pending), 32'h01);
        chk("coll_stable", 32'(stable_out), 32'h04);
        step();
        clear = 8'h00;
        chk("coll_cleared", 32'(pending), 32'h00);
        chk("coll_irq_hold", 32'(irq), 32'h1);
        step();
        chk("coll_irq_low", 32'(irq), 32'h0);

        // Channel 5 with events disabled, then reset mid-debounce.
        async_in = 8'h24;
        repeat (6) step();
        chk("off_stable", 32'(stable_out), 32'h24);
        chk("off_rise", 32'(rise_pulse), 32'h20);
        chk("off_pending", 32'(pending), 32'h00);
        step();
        chk("off_irq", 32'(irq), 32'h0);
        async_in = 8'h04;
        repeat (4) step();
        chk("mid_stable", 32'(stable_out), 32'h24);
        nreset = 1'b0;
        step();
        chk("mid_rst_stable", 32'(stable_out), 32'h01);
        chk("mid_rst_flags", 32'({rise_pulse, fall_pulse, pending}), 32'h0);
        nreset   = 1'b1;
        async_in = 8'h01;
        repeat (3) step();

        // Full latency after reset shows the counter restarted from zero.
        irq_mode = 16'h0453;
        async_in = 8'h21;
        repeat (5) step();
        chk("post_rst_early", 32'(stable_out), 32'h01);
        step();
        chk("post_rst_stable", 32'(stable_out), 32'h21);
        chk("post_rst_pending", 32'(pending), 32'h20);
        step();
        chk("post_rst_irq", 32'(irq), 32'h1);

        // Mixed modes and patterns, checked against the model only.
        irq_mode = 16'hE4B1;
        tbl[0] = '{8'hFF, 6};
        tbl[1] = '{8'h00, 2};
        tbl[2] = '{8'h00, 5};
        tbl[3] = '{8'hA5, 4};
        tbl[4] = '{8'h5A, 3};
        tbl[5] = '{8'hA5, 9};
        tbl[6] = '{8'h0F, 1};
        tbl[7] = '{8'hF0, 7};
        for (int t = 0; t < 8; t++) begin
            async_in = tbl[t].val;
            for (int h = 0; h < tbl[t].hold; h++) begin
                clear = (h == 1) ? 8'h0F : 8'h00;
                step();
            end
        end
        chk("mix_stable", 32'(stable_out), 32'hF0);
        clear = 8'hFF;
        step();
        clear = 8'h00;
        chk("mix_cleared", 32'(pending), 32'h00);
        step();
        chk("mix_irq_low", 32'(irq), 32'h0);
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter CHANNELS, default 8: number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth (2..4).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive mismatching synchronized samples required to accept a new level (1..65535).
REQ-004 SHALL have parameter INIT, default all-zero, width CHANNELS: reset level of the synchronizer chains and of stable_out.
REQ-005 SHALL have port clk  input  1: single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port nreset  input  1: reset is synchronous and active-low.
REQ-007 SHALL have port async_in  input  CHANNELS: asynchronous raw inputs, for example external interrupt lines, DTR and DIP switches.
REQ-008 SHALL have port irq_mode  input  2*CHANNELS: per channel i, bits [2i+1:2i] are 00 off, 01 rise, 10 fall, 11 both.
REQ-009 SHALL have port clear  input  CHANNELS: write-1-to-clear strobes for pending, one bit per channel.
REQ-010 SHALL have port stable_out  output  CHANNELS: debounced level.
REQ-011 SHALL have port rise_pulse  output  CHANNELS: one-cycle pulse on an accepted 0->1 transition.
REQ-012 SHALL have port fall_pulse  output  CHANNELS: one-cycle pulse on an accepted 1->0 transition.
REQ-013 SHALL have port pending  output  CHANNELS: sticky event flags.
REQ-014 SHALL have port irq  output  1: registered OR of pending.

Function
REQ-015 SHALL pass each channel through a SYNC_STAGES-deep flop chain; sync[i] is the last stage.
REQ-016 SHALL keep a per-channel counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-017 SHALL reset the counter to 0 on any edge where sync[i]==stable_out[i].
REQ-018 SHALL increment the counter on any edge where sync[i]!=stable_out[i] and counter<DEBOUNCE_CYCLES-1.
REQ-019 SHALL load stable_out[i]<=sync[i] and counter<=0 on the edge where sync[i]!=stable_out[i] and counter==DEBOUNCE_CYCLES-1.
REQ-020 SHALL give a latency of SYNC_STAGES+DEBOUNCE_CYCLES-1 edges, counted from the first edge that samples a new steady level, to the stable_out update.
REQ-021 SHALL reject any input pulse held for fewer than DEBOUNCE_CYCLES sampling edges, with no change on stable_out or on the pulse outputs.
REQ-022 SHALL register rise_pulse[i]/fall_pulse[i] high on the same edge that stable_out[i] changes, low on the next edge, mutually exclusive, and never both in one cycle.
REQ-023 SHALL set pending[i] on an edge where an accepted transition matches irq_mode for channel i; mode 00 never sets it.
REQ-024 SHALL clear pending[i] on an edge with clear[i]=1 and no simultaneous set; simultaneous set and clear leaves pending[i]=1.
REQ-025 SHALL update irq one edge after pending, with irq<=|pending.
REQ-026 SHALL apply an irq_mode change from the next edge onward; it SHALL NOT retroactively set or clear pending.
REQ-027 SHALL NOT saturate or wrap the counter beyond DEBOUNCE_CYCLES-1.

Reset
REQ-028 SHALL, on any clk edge with nreset=0, load sync chains and stable_out with INIT, counters with 0, rise_pulse/fall_pulse/pending with 0, and irq with 0, overriding all other updates including mid-debounce.
REQ-029 SHALL generate no pulse and no pending on reset release when async_in equals INIT.

Verification (CHANNELS=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INIT=8'h01)
REQ-030 SHALL cover reset: nreset low 3 edges, async_in=8'h01, then release -> stable_out=8'h01, pending=0, irq=0, no pulse for 20 cycles.
REQ-031 SHALL cover a clean rise: ch2 mode 01, async_in[2] 0->1 first sampled at edge k -> stable_out[2]=1 and rise_pulse[2]=1 after edge k+5, rise_pulse[2]=0 after k+6, pending[2]=1 after k+5, irq=1 after k+6.
REQ-032 SHALL cover a glitch: ch3 high for exactly 3 sampling edges -> stable_out[3], pulses and pending[3] unchanged.
REQ-033 SHALL cover set/clear collision: ch0 mode 11, 1->0 accepted on the same edge as clear[0]=1 -> fall_pulse[0]=1, pending[0]=1; clear[0]=1 on the next edge -> pending[0]=0, and irq=0 one edge later.
REQ-034 SHALL cover mode off and mid-operation reset: ch5 mode 00, toggle accepted -> stable_out[5] and rise_pulse[5] follow, pending[5] stays 0; toggle again with nreset=0 while counter==2 -> counter 0, stable_out=8'h01.
